gpu_core: RTL and testbench
===========================

// Module: gpu_core
// PURPOSE
//  Multi-thread SIMT successor to the single-thread datapath: NUM_THREADS lanes run one shared
//  instruction stream in lock-step. Each lane has its own register file and ALU. A multi-cycle
//  FSM drives fetch and execute over valid/ack handshakes. Lane memory accesses are serialised
//  onto one shared data-memory port. Sits between the block dispatcher (start/done) and memories.
// PARAMETERS
//  NUM_THREADS  4   lanes per core (1..16); lane i has thread_idx = i
//  DATA_W       16  register / ALU / data-memory width
//  PC_W         16  program counter and instruction address width
// PORTS
//  clk         in   1            clock
//  reset       in   1            asynchronous, active-high reset
//  start       in   1            launch block; sampled only in IDLE or DONE
//  block_idx   in   DATA_W       block index, readable as r13 in every lane
//  block_dim   in   DATA_W       threads per block, readable as r14; lanes i>=block_dim inactive
//  done        out  1            high while in DONE
//  imem_req    out  1            instruction fetch request
//  imem_addr   out  PC_W         fetch address (= pc)
//  imem_valid  in   1            imem_data valid; completes the fetch
//  imem_data   in   32           instruction word
//  dmem_req    out  1            data request, held until dmem_ack
//  dmem_we     out  1            1 = store, 0 = load
//  dmem_addr   out  DATA_W       RS1 + imm of the serviced lane
//  dmem_wdata  out  DATA_W       RS2 of the serviced lane
//  dmem_rdata  in   DATA_W       load data, valid with dmem_ack
//  dmem_ack    in   1            completes the current data access
// BEHAVIOUR
//  Encoding: [31:16] imm, [15:12] op, [11:8] rd, [7:4] rs2, [3:0] rs1.
//  Ops 0-5: ADD SUB MUL AND OR XOR; 6: LW rd=M[rs1+imm]; 7: SW M[rs1+imm]=rs2; F: HALT; others NOP.
//  Arithmetic wraps modulo 2^DATA_W. MUL keeps the low DATA_W bits.
//  r13/r14/r15 read block_idx/block_dim/thread_idx. Writes to r13-r15 are dropped.
//  FSM states: IDLE -> FETCH -> EXEC -> (MEM) -> IDLE/FETCH/DONE.
//   IDLE: wait for start. On start: pc=0, r0-r12 of every lane cleared, go to FETCH.
//   FETCH: imem_req=1 until imem_valid; latch imem_data into ir; then go to EXEC.
//   EXEC: ALU ops write rd in all active lanes in one cycle, pc+=1, go to FETCH.
//         LW/SW: lane counter=first active lane, go to MEM. If no lane is active, pc+=1, go to FETCH.
//         HALT: go to DONE; pc does not change.
//   MEM: dmem_req=1 for the current lane, with addr/we/wdata stable until ack.
//        On ack: an LW writes dmem_rdata to rd of that lane, then advance to the next active lane.
//        After the last active lane, pc+=1 and go to FETCH. Inactive lanes are skipped, zero cycles.
//   DONE: done=1. A start relaunches exactly as from IDLE. A start while busy is ignored.
//  Throughput: ALU op = fetch latency + 1 cycle. LW/SW = fetch + 1 + sum of per-lane ack latencies.
//  Lane activity: lane i active iff i < block_dim. block_dim=0 leaves all lanes inactive.
//  block_dim >= NUM_THREADS makes all lanes active.
//  pc wraps from 2^PC_W-1 to 0.
//  Reset state: IDLE. pc, ir, lane counter and all registers = 0. done, imem_req, dmem_req,
//   dmem_we = 0. imem_addr, dmem_addr, dmem_wdata = 0.
//  Reset mid-operation aborts any outstanding handshake with no write.
//  A late ack after reset is ignored.
//  imem_valid outside FETCH and dmem_ack outside MEM are ignored.
// STRUCTURE
//  gpu_pkg: opcode_e, state_e, field-slice constants, and the special register indices 13/14/15.
//  Sub-module gpu_lane, one instance per lane (generate loop). It holds the 16xDATA_W regfile
//   (2 read ports, 1 write port) and the combinational ALU. It gets thread_idx as a constant.
//  gpu_core holds the FSM, pc, ir, lane counter, active mask, and the dmem mux/demux.
// TESTING
//  1. NUM_THREADS=4, block_dim=4: program ADD r1=r15+r15; HALT.
//     -> r1 = {0,2,4,6}. done rises 1 cycle after HALT exec.
//  2. SW M[r15+0x10]=r15, then LW r2=M[r15+0x10], with ack 3 cycles after req.
//     -> 4 stores to 0x10..0x13 in lane order. r2 = {0,1,2,3}. Each req held until its ack.
//  3. block_dim=2, same SW program -> only lanes 0,1 issue. r1 writes of lanes 2,3 stay 0.
//  4. block_dim=0 with LW -> no dmem_req. pc advances. HALT reached.
//  5. MUL 0x0100*0x0100 -> 0x0000. SUB 0-1 -> 0xFFFF. Write to r15 -> r15 still reads lane idx.
//  6. Reset asserted mid-MEM with req pending -> dmem_req=0 and FSM in IDLE on the next edge.
//     A later ack is ignored. start runs from pc=0 with r0-r12 cleared.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared types and instruction-field constants for the SIMT core and its lanes.
// Instruction word: [31:16] imm, [15:12] op, [11:8] rd, [7:4] rs2, [3:0] rs1.
package gpu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_MUL  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_LW   = 4'h6,
        OP_SW   = 4'h7,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_MEM,
        ST_DONE
    } state_e;

    localparam int IMM_LSB = 16;
    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 8;
    localparam int RS2_LSB = 4;
    localparam int RS1_LSB = 0;

    localparam logic [3:0] REG_BIDX = 4'd13;
    localparam logic [3:0] REG_BDIM = 4'd14;
    localparam logic [3:0] REG_TIDX = 4'd15;

endpackage

// File: rtl/gpu_lane.sv
// One SIMT lane: 13 writable registers, read-only r13-r15 block/thread ids, and the ALU.
module gpu_lane
    import gpu_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int THREAD_IDX = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clear,
    input  logic              i_we,
    input  logic [3:0]        i_rd,
    input  logic [3:0]        i_rs1,
    input  logic [3:0]        i_rs2,
    input  logic [3:0]        i_op,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_block_idx,
    input  logic [DATA_W-1:0] i_block_dim,
    output logic [DATA_W-1:0] o_rs1_val,
    output logic [DATA_W-1:0] o_rs2_val,
    output logic [DATA_W-1:0] o_alu
);

    localparam int NUM_GPR = 13;

    logic [DATA_W-1:0] r_regs [NUM_GPR];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < NUM_GPR; k++) r_regs[k] <= '0;
        end else if (i_clear) begin
            for (int k = 0; k < NUM_GPR; k++) r_regs[k] <= '0;
        end else if (i_we && (i_rd < REG_BIDX)) begin
            r_regs[i_rd] <= i_wdata;
        end
    end

    function automatic logic [DATA_W-1:0] read_reg(input logic [3:0] idx);
        case (idx)
            REG_BIDX: return i_block_idx;
            REG_BDIM: return i_block_dim;
            REG_TIDX: return DATA_W'(THREAD_IDX);
            default:  return r_regs[idx];
        endcase
    endfunction

    assign o_rs1_val = read_reg(i_rs1);
    assign o_rs2_val = read_reg(i_rs2);

    always_comb begin
        o_alu = '0;
        case (i_op)
            OP_ADD:  o_alu = o_rs1_val + o_rs2_val;
            OP_SUB:  o_alu = o_rs1_val - o_rs2_val;
            OP_MUL:  o_alu = o_rs1_val * o_rs2_val;
            OP_AND:  o_alu = o_rs1_val & o_rs2_val;
            OP_OR:   o_alu = o_rs1_val | o_rs2_val;
            OP_XOR:  o_alu = o_rs1_val ^ o_rs2_val;
            default: o_alu = '0;
        endcase
    end

endmodule

// File: rtl/gpu_core.sv
// Lock-step SIMT core: shared fetch/execute FSM over NUM_THREADS lanes, with lane
// memory accesses serialised onto a single data-memory port.
module gpu_core
    import gpu_pkg::*;
#(
    parameter int NUM_THREADS = 4,
    parameter int DATA_W      = 16,
    parameter int PC_W        = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_block_idx,
    input  logic [DATA_W-1:0] i_block_dim,
    output logic              o_done,
    output logic              o_imem_req,
    output logic [PC_W-1:0]   o_imem_addr,
    input  logic              i_imem_valid,
    input  logic [31:0]       i_imem_data,
    output logic              o_dmem_req,
    output logic              o_dmem_we,
    output logic [DATA_W-1:0] o_dmem_addr,
    output logic [DATA_W-1:0] o_dmem_wdata,
    input  logic [DATA_W-1:0] i_dmem_rdata,
    input  logic              i_dmem_ack
);

    localparam int LANE_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

    state_e            r_state, w_state_next;
    logic [PC_W-1:0]   r_pc, w_pc_next;
    logic [31:0]       r_ir, w_ir_next;
    logic [LANE_W-1:0] r_lane, w_lane_next;

    logic w_clear, w_alu_we, w_mem_we, w_last_lane, w_in_mem;
    logic [3:0] w_op, w_rd, w_rs1, w_rs2;
    logic [DATA_W-1:0] w_imm, w_lane_ext;
    logic [NUM_THREADS-1:0] w_active, w_lane_we;
    logic [DATA_W-1:0] w_rs1_val [NUM_THREADS];
    logic [DATA_W-1:0] w_rs2_val [NUM_THREADS];
    logic [DATA_W-1:0] w_alu_val [NUM_THREADS];
    logic [DATA_W-1:0] w_lane_wdata [NUM_THREADS];

    assign w_op  = r_ir[OP_LSB +: 4];
    assign w_rd  = r_ir[RD_LSB +: 4];
    assign w_rs1 = r_ir[RS1_LSB +: 4];
    assign w_rs2 = r_ir[RS2_LSB +: 4];
    assign w_imm = DATA_W'(r_ir[IMM_LSB +: 16]);

    // Active lanes always form a prefix 0..block_dim-1, so the first active lane is
    // lane 0 and the serviced lane is the last one once lane+1 reaches block_dim.
    assign w_lane_ext  = DATA_W'(r_lane);
    assign w_last_lane = (int'(r_lane) >= NUM_THREADS - 1) ||
                         ((w_lane_ext + DATA_W'(1)) >= i_block_dim);

    for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_lane
        assign w_active[gi]     = i_block_dim > DATA_W'(gi);
        assign w_lane_we[gi]    = (w_alu_we && w_active[gi]) ||
                                  (w_mem_we && (r_lane == LANE_W'(gi)));
        assign w_lane_wdata[gi] = w_mem_we ? i_dmem_rdata : w_alu_val[gi];

        gpu_lane #(
            .DATA_W     (DATA_W),
            .THREAD_IDX (gi)
        ) u_lane (
            .i_clk       (i_clk),
            .i_reset     (i_reset),
            .i_clear     (w_clear),
            .i_we        (w_lane_we[gi]),
            .i_rd        (w_rd),
            .i_rs1       (w_rs1),
            .i_rs2       (w_rs2),
            .i_op        (w_op),
            .i_wdata     (w_lane_wdata[gi]),
            .i_block_idx (i_block_idx),
            .i_block_dim (i_block_dim),
            .o_rs1_val   (w_rs1_val[gi]),
            .o_rs2_val   (w_rs2_val[gi]),
            .o_alu       (w_alu_val[gi])
        );
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
            r_lane  <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_ir    <= w_ir_next;
            r_lane  <= w_lane_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_ir_next    = r_ir;
        w_lane_next  = r_lane;
        w_clear      = 1'b0;
        w_alu_we     = 1'b0;
        w_mem_we     = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    w_state_next = ST_FETCH;
                    w_pc_next    = '0;
                    w_clear      = 1'b1;
                end
            end
            ST_FETCH: begin
                if (i_imem_valid) begin
                    w_ir_next    = i_imem_data;
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (w_op)
                    OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR: begin
                        w_alu_we     = 1'b1;
                        w_pc_next    = r_pc + 1'b1;
                        w_state_next = ST_FETCH;
                    end
                    OP_LW, OP_SW: begin
                        if (w_active[0]) begin
                            w_lane_next  = '0;
                            w_state_next = ST_MEM;
                        end else begin
                            w_pc_next    = r_pc + 1'b1;
                            w_state_next = ST_FETCH;
                        end
                    end
                    OP_HALT: w_state_next = ST_DONE;
                    default: begin
                        w_pc_next    = r_pc + 1'b1;
                        w_state_next = ST_FETCH;
                    end
                endcase
            end
            ST_MEM: begin
                if (i_dmem_ack) begin
                    w_mem_we = (w_op == OP_LW);
                    if (w_last_lane) begin
                        w_pc_next    = r_pc + 1'b1;
                        w_state_next = ST_FETCH;
                    end else begin
                        w_lane_next = r_lane + 1'b1;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_in_mem     = (r_state == ST_MEM);
    assign o_done       = (r_state == ST_DONE);
    assign o_imem_req   = (r_state == ST_FETCH);
    assign o_imem_addr  = r_pc;
    assign o_dmem_req   = w_in_mem;
    assign o_dmem_we    = w_in_mem && (w_op == OP_SW);
    assign o_dmem_addr  = w_in_mem ? (w_rs1_val[r_lane] + w_imm) : '0;
    assign o_dmem_wdata = w_in_mem ? w_rs2_val[r_lane] : '0;

endmodule

// File: tb/tb_gpu_core.sv
// Randomised bench for gpu_core: an instruction-level reference model predicts every
// data-memory transaction, and a monitor checks them against the DUT as they complete.
module tb_gpu_core;

    localparam int NT = 4;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [15:0] block_idx, block_dim;
    logic        done, imem_req, imem_valid;
    logic [15:0] imem_addr;
    logic [31:0] imem_data;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;

    always #5 clk = ~clk;

    gpu_core #(.NUM_THREADS(NT), .DATA_W(16), .PC_W(16)) dut (
        .i_clk(clk), .i_reset(rst), .i_start(start),
        .i_block_idx(block_idx), .i_block_dim(block_dim),
        .o_done(done), .o_imem_req(imem_req), .o_imem_addr(imem_addr),
        .i_imem_valid(imem_valid), .i_imem_data(imem_data),
        .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr),
        .o_dmem_wdata(dmem_wdata), .i_dmem_rdata(dmem_rdata), .i_dmem_ack(dmem_ack)
    );

    typedef struct {
        bit        we;
        bit [15:0] addr;
        bit [15:0] wdata;
    } txn_t;

    txn_t      exp_q[$];
    bit [31:0] prog[$];
    bit [15:0] mem_ref [65536];
    bit [15:0] mem_dut [65536];
    int        n_tests = 0, n_fail = 0;
    int        ack_lat = -1;
    bit        hold_ack = 1'b0, inject_ack = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic bit [31:0] enc(input int op, input int rd, input int rs2,
                                      input int rs1, input int imm);
        return {imm[15:0], op[3:0], rd[3:0], rs2[3:0], rs1[3:0]};
    endfunction

    task automatic add_dump(input int r);
        prog.push_back(enc(7, 0, r, 15, 16'h0100 + r * 8));
    endtask

    // Instruction-level model: runs the program, predicting stores/loads in lane order.
    task automatic run_model(input bit [15:0] bidx, input bit [15:0] bdim, output int halt_pc);
        bit [15:0] regs [NT][16];
        bit [31:0] w;
        bit [15:0] a, b, res, addr, imm;
        int nact, pc, op, rd, rs1, rs2;
        nact = (bdim > NT) ? NT : int'(bdim);
        for (int l = 0; l < NT; l++) begin
            for (int r = 0; r < 13; r++) regs[l][r] = 16'h0;
            regs[l][13] = bidx;
            regs[l][14] = bdim;
            regs[l][15] = 16'(l);
        end
        pc = 0;
        forever begin
            w = (pc < prog.size()) ? prog[pc] : 32'h0000F000;
            op = int'(w[15:12]); rd = int'(w[11:8]); rs2 = int'(w[7:4]); rs1 = int'(w[3:0]);
            imm = w[31:16];
            if (op == 15) break;
            for (int l = 0; l < nact; l++) begin
                a = regs[l][rs1];
                b = regs[l][rs2];
                res = 16'h0;
                case (op)
                    0: res = 16'(int'(a) + int'(b));
                    1: res = 16'(int'(a) - int'(b));
                    2: res = 16'(int'(a) * int'(b));
                    3: res = a & b;
                    4: res = a | b;
                    5: res = a ^ b;
                    6: begin
                        addr = 16'(int'(a) + int'(imm));
                        exp_q.push_back('{we: 1'b0, addr: addr, wdata: b});
                        res = mem_ref[addr];
                    end
                    7: begin
                        addr = 16'(int'(a) + int'(imm));
                        exp_q.push_back('{we: 1'b1, addr: addr, wdata: b});
                        mem_ref[addr] = b;
                    end
                    default: res = 16'h0;
                endcase
                if (op <= 6 && rd < 13) regs[l][rd] = res;
            end
            pc++;
        end
        halt_pc = pc;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_program(input string name, input bit [15:0] bidx, input bit [15:0] bdim);
        int hpc;
        run_model(bidx, bdim, hpc);
        block_idx = bidx;
        block_dim = bdim;
        pulse_start();
        for (int c = 0; c < 20000 && !done; c++) @(negedge clk);
        check({name, " done reached"}, done, 1'b1);
        check({name, " halt pc"}, imem_addr, 16'(hpc));
        check({name, " scoreboard drained"}, exp_q.size(), 0);
        if (!done) begin
            @(posedge clk); #1 rst = 1'b1;
            @(posedge clk); #1 rst = 1'b0;
        end
        exp_q.delete();
        $display("[TB] program %s bdim=%0d done, %0d tests so far", name, bdim, n_tests);
    endtask

    // Instruction memory responder: random 0-2 cycle latency, one-cycle valid pulse.
    initial begin
        imem_valid = 1'b0;
        imem_data  = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (!rst && imem_req) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                if (!rst && imem_req) begin
                    imem_data  = (imem_addr < prog.size()) ? prog[imem_addr] : 32'h0000F000;
                    imem_valid = 1'b1;
                    @(posedge clk); #1;
                    imem_valid = 1'b0;
                end
            end
        end
    end

    // Data memory responder.
    initial begin
        int lat;
        dmem_ack   = 1'b0;
        dmem_rdata = 16'h0;
        forever begin
            @(posedge clk); #1;
            if (!rst && dmem_req && !hold_ack) begin
                lat = (ack_lat >= 0) ? ack_lat : int'($urandom_range(0, 3));
                repeat (lat) begin @(posedge clk); #1; end
                if (!rst && dmem_req) begin
                    if (dmem_we) mem_dut[dmem_addr] = dmem_wdata;
                    else         dmem_rdata = mem_dut[dmem_addr];
                    dmem_ack = 1'b1;
                    @(posedge clk); #1;
                    dmem_ack   = 1'b0;
                    dmem_rdata = 16'h0;
                end
            end else begin
                dmem_ack   = inject_ack;
                dmem_rdata = inject_ack ? 16'hBEEF : 16'h0;
            end
        end
    end

    // Monitor: scoreboard pops on each completed data access; checks hold and HALT timing.
    initial begin
        bit        pend;
        bit        h_we;
        bit [15:0] h_addr, h_wdata, halt_pc;
        int        halt_cnt;
        txn_t      t;
        pend = 1'b0;
        halt_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
                halt_cnt = 0;
                continue;
            end
            if (halt_cnt > 0) begin
                halt_cnt--;
                if (halt_cnt == 1) begin
                    check("done low in HALT exec cycle", done, 1'b0);
                end else begin
                    check("done one cycle after HALT exec", done, 1'b1);
                    check("pc unchanged by HALT", imem_addr, halt_pc);
                end
            end
            if (imem_req && imem_valid && imem_data[15:12] == 4'hF) begin
                halt_cnt = 2;
                halt_pc  = imem_addr;
            end
            if (dmem_req) begin
                if (pend)
                    check("dmem request held stable", {dmem_we, dmem_addr, dmem_wdata},
                          {h_we, h_addr, h_wdata});
                h_we = dmem_we; h_addr = dmem_addr; h_wdata = dmem_wdata;
                if (dmem_ack) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL dmem unexpected access: got we=%0d addr=%h, expected none",
                                 dmem_we, dmem_addr);
                    end else begin
                        t = exp_q.pop_front();
                        check("dmem we", dmem_we, t.we);
                        check("dmem addr", dmem_addr, t.addr);
                        if (t.we) check("dmem wdata", dmem_wdata, t.wdata);
                    end
                    pend = 1'b0;
                end else begin
                    pend = 1'b1;
                end
            end else begin
                if (pend) check("dmem req held until ack", dmem_req, 1'b1);
                pend = 1'b0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, op;
        bit [15:0] v;
        for (int i = 0; i < 65536; i++) begin
            v = 16'($urandom);
            mem_ref[i] = v;
            mem_dut[i] = v;
        end
        rst = 1'b1; start = 1'b0; block_idx = 16'h0; block_dim = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset done", done, 1'b0);
        check("reset imem_req", imem_req, 1'b0);
        check("reset imem_addr", imem_addr, 16'h0);
        check("reset dmem_req", dmem_req, 1'b0);
        check("reset dmem_we", dmem_we, 1'b0);
        check("reset dmem_addr", dmem_addr, 16'h0);
        check("reset dmem_wdata", dmem_wdata, 16'h0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle without start imem_req", imem_req, 1'b0);

        // r1 = r15 + r15
        prog.delete();
        prog.push_back(enc(0, 1, 15, 15, 0));
        add_dump(1);
        prog.push_back(enc(15, 0, 0, 0, 0));
        run_program("add_tidx", 16'h0007, 16'd4);

        // store then reload thread index, fixed ack latency
        ack_lat = 3;
        prog.delete();
        prog.push_back(enc(7, 0, 15, 15, 16'h0010));
        prog.push_back(enc(6, 2, 0, 15, 16'h0010));
        add_dump(2);
        prog.push_back(enc(15, 0, 0, 0, 0));
        run_program("sw_lw", 16'h0001, 16'd4);
        ack_lat = -1;

        // partial block: only lanes 0,1 active
        prog.delete();
        prog.push_back(enc(0, 1, 15, 15, 0));
        prog.push_back(enc(7, 0, 15, 15, 16'h0010));
        add_dump(1);
        prog.push_back(enc(15, 0, 0, 0, 0));
        run_program("partial", 16'h0002, 16'd2);

        // empty block: memory ops issue nothing, pc still advances
        prog.delete();
        prog.push_back(enc(6, 2, 0, 15, 16'h0010));
        add_dump(2);
        prog.push_back(enc(15, 0, 0, 0, 0));
        run_program("empty", 16'h0003, 16'd0);

        // wrap-around arithmetic and dropped write to r15
        mem_ref[16'h20] = 16'h0100; mem_dut[16'h20] = 16'h0100;
        mem_ref[16'h21] = 16'h0001; mem_dut[16'h21] = 16'h0001;
        prog.delete();
        prog.push_back(enc(6, 3, 0, 0, 16'h0020));
        prog.push_back(enc(6, 6, 0, 0, 16'h0021));
        prog.push_back(enc(2, 4, 3, 3, 0));
        prog.push_back(enc(1, 5, 6, 0, 0));
        prog.push_back(enc(0, 15, 3, 3, 0));
        prog.push_back(enc(9, 7, 3, 3, 0));
        prog.push_back(enc(0, 7, 0, 15, 0));
        add_dump(4); add_dump(5); add_dump(7); add_dump(15);
        prog.push_back(enc(15, 0, 0, 0, 0));
        run_program("arith_edges", 16'h0004, 16'd9);

        for (int it = 0; it < 20; it++) begin
            prog.delete();
            len = $urandom_range(4, 16);
            for (int k = 0; k < len; k++) begin
                op = $urandom_range(0, 9);
                if (op >= 8) op = $urandom_range(8, 14);
                prog.push_back(enc(op, $urandom_range(0, 15), $urandom_range(0, 15),
                                   $urandom_range(0, 15), int'($urandom_range(0, 65535))));
            end
            for (int r = 0; r < 16; r++) add_dump(r);
            prog.push_back(enc(15, 0, 0, 0, 0));
            run_program("random", 16'($urandom), 16'($urandom_range(0, 6)));
        end

        // reset while a data request is pending
        hold_ack = 1'b1;
        prog.delete();
        prog.push_back(enc(6, 2, 0, 15, 16'h0010));
        add_dump(2);
        prog.push_back(enc(15, 0, 0, 0, 0));
        begin
            int hpc;
            run_model(16'h0005, 16'd4, hpc);
        end
        block_dim = 16'd4;
        pulse_start();
        for (int c = 0; c < 200 && !dmem_req; c++) @(negedge clk);
        check("reset test reached MEM", dmem_req, 1'b1);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("reset mid-MEM dmem_req", dmem_req, 1'b0);
        check("reset mid-MEM imem_req", imem_req, 1'b0);
        check("reset mid-MEM done", done, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        exp_q.delete();
        hold_ack = 1'b0;
        @(posedge clk); #2 inject_ack = 1'b1;
        @(posedge clk); #2 inject_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("late ack ignored dmem_req", dmem_req, 1'b0);
        check("late ack ignored imem_req", imem_req, 1'b0);
        check("late ack ignored done", done, 1'b0);
        prog.delete();
        for (int r = 0; r < 16; r++) add_dump(r);
        prog.push_back(enc(15, 0, 0, 0, 0));
        run_program("after_reset", 16'h0006, 16'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
